// File: rtl/fetch_ctl_pkg.sv
// Shared definitions for the instruction fetch controller.
//   NOP              : instruction presented while the buffer is empty
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_state_e    : fetch FSM state encoding
//   fetch_entry_t    : one instruction-buffer entry {pc, instr}
package fetch_ctl_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StKill
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ctl_if.sv
// Fetch controller bus bundle: instruction-memory request/response, redirect
// from later stages, and the instruction stream to decode.
//   master : fetch controller side
//   slave  : memory / pipeline environment side
interface fetch_ctl_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instruction, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, stall
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instruction, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, stall
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with first-word-fall-through head.
//   clk, rst  : clock, asynchronous active-high reset
//   push      : write push_data (ignored when full)
//   pop       : drop head entry (ignored when empty)
//   flush     : empty the buffer; wins over push and pop
//   head      : oldest entry, valid when !empty
//   empty     : no entries held
//   count     : number of entries held
module fetch_fifo
  import fetch_ctl_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t  mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers wrap naturally since Depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; only entries behind valid pointers are observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Request gating upstream must never let a response land in a full buffer.
  push_when_full_a: assert property (@(posedge clk) disable iff (rst) !(push && full && !flush));

endmodule

// File: rtl/fetch_ctl.sv
// Instruction fetch controller: issues one outstanding word fetch at a time,
// buffers responses for decode and handles redirects by flushing and killing
// any in-flight response.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_ctl_if.master (imem request/response, redirect, stall,
//              instruction stream to decode)
module fetch_ctl
  import fetch_ctl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_ctl_if.master   bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;

  logic                       req_valid, push, pop, flush;
  logic                       fifo_empty;
  logic [$clog2(BUF_DEPTH):0] fifo_count;
  fetch_entry_t               head, push_entry;
  logic [31:0]                redirect_target;

  assign redirect_target = {bus.redirect_pc[31:2], 2'b00};
  assign push_entry      = '{pc: req_pc_q, instr: bus.imem_rsp_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    req_valid = 1'b0;
    push      = 1'b0;
    // Any redirect flushes the buffer and retargets the PC, whatever the state.
    flush     = bus.redirect_valid;

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        req_valid = !bus.redirect_valid && (32'(fifo_count) < BUF_DEPTH);
        if (req_valid && bus.imem_req_ready) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (bus.imem_rsp_valid) begin
          push    = !bus.redirect_valid;
          state_d = StReq;
        end else if (bus.redirect_valid) begin
          // Response still in flight: it must be swallowed when it arrives.
          state_d = StKill;
        end
      end
      StKill: if (bus.imem_rsp_valid) state_d = StReq;
      default: state_d = StIdle;
    endcase

    if (bus.redirect_valid) pc_d = redirect_target;
  end

  assign pop = !fifo_empty && !bus.stall && !bus.redirect_valid;

  fetch_fifo #(
    .Depth(BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q;
  assign bus.instr_valid    = !fifo_empty;
  assign bus.instruction    = fifo_empty ? NOP : head.instr;
  assign bus.instr_pc       = fifo_empty ? 32'h0 : head.pc;

endmodule

// File: tb/tb_fetch_ctl.sv
module tb_fetch_ctl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  fetch_ctl_if bus_if ();
  fetch_ctl_if bus2_if ();

  fetch_ctl #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  fetch_ctl #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_wrap (
    .clk (clk),
    .rst (rst2),
    .bus (bus2_if)
  );

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (buffer as a queue) ----------------
  typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;
  ent_t        mq[$];
  bit          m_started, m_out, m_killed;
  logic [31:0] m_pc, m_out_addr;

  // ---------------- memory model ----------------
  bit          mem_pend;
  int          mem_cnt;
  int          mem_lat_max;
  bit          mem_rand_data;
  logic [31:0] mem_data;

  task automatic clear_models();
    mq.delete();
    m_started = 0; m_out = 0; m_killed = 0;
    m_pc = 32'h0; m_out_addr = 32'h0;
    mem_pend = 0; mem_cnt = 0; mem_data = 32'h0;
  endtask

  // Enter at a negedge; assert reset, check reset outputs, release at a negedge.
  task automatic do_reset();
    rst = 1'b1;
    bus_if.imem_req_ready = 0; bus_if.imem_rsp_valid = 0; bus_if.imem_rsp_data = 0;
    bus_if.redirect_valid = 0; bus_if.redirect_pc = 0; bus_if.stall = 0;
    #1;
    check("rst_req_valid", 32'(bus_if.imem_req_valid), 32'h0);
    check("rst_addr", bus_if.imem_addr, 32'h0);
    check("rst_instr_valid", 32'(bus_if.instr_valid), 32'h0);
    check("rst_instruction", bus_if.instruction, 32'h0000_0013);
    check("rst_instr_pc", bus_if.instr_pc, 32'h0);
    clear_models();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle against the model + memory responder; enter and leave at a negedge.
  task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc, input bit stl);
    bit          rsp, exp_req, hs, do_pop, do_push;
    logic [31:0] rdata;
    rsp   = mem_pend && (mem_cnt == 0);
    rdata = rsp ? mem_data : 32'h0;
    bus_if.imem_req_ready = rdy;
    bus_if.imem_rsp_valid = rsp;
    bus_if.imem_rsp_data  = rdata;
    bus_if.redirect_valid = redir;
    bus_if.redirect_pc    = rpc;
    bus_if.stall          = stl;
    #1;
    exp_req = m_started && !m_out && (mq.size() < 2) && !redir;
    check("req_valid", 32'(bus_if.imem_req_valid), 32'(exp_req));
    if (exp_req) check("imem_addr", bus_if.imem_addr, m_pc);
    check("instr_valid", 32'(bus_if.instr_valid), 32'(mq.size() > 0));
    check("instruction", bus_if.instruction, (mq.size() > 0) ? mq[0].data : 32'h0000_0013);
    check("instr_pc", bus_if.instr_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);

    // memory reacts to the real bus
    if (rsp) mem_pend = 0;
    else if (mem_pend) mem_cnt--;
    if (bus_if.imem_req_valid && rdy) begin
      mem_pend = 1;
      mem_cnt  = $urandom_range(mem_lat_max, 0);
      mem_data = mem_rand_data ? $urandom : (bus_if.imem_addr >> 2);
    end

    // model update from the behavioural rules
    hs      = exp_req && rdy;
    do_pop  = (mq.size() > 0) && !stl && !redir;
    do_push = rsp && m_out && !m_killed && !redir;
    if (rsp && m_out) m_out = 0;
    if (redir) begin
      if (m_out) m_killed = 1;
      mq.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{pc: m_out_addr, data: rdata});
    end
    if (hs) begin
      m_out = 1; m_killed = 0; m_out_addr = m_pc; m_pc = m_pc + 32'd4;
    end
    m_started = 1;
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rdy; bit rsp; logic [31:0] rdata; bit redir; logic [31:0] rpc; bit stl;
    bit e_req; logic [31:0] e_addr; bit e_iv; logic [31:0] e_instr; logic [31:0] e_ipc;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit rdy, bit rsp, logic [31:0] rdata, bit redir, logic [31:0] rpc,
                              bit stl, bit e_req, logic [31:0] e_addr, bit e_iv,
                              logic [31:0] e_instr, logic [31:0] e_ipc);
    vec_t v;
    v = '{rdy, rsp, rdata, redir, rpc, stl, e_req, e_addr, e_iv, e_instr, e_ipc};
    return v;
  endfunction

  // ---------------- wrap-around instance (ready memory) ----------------
  logic [31:0] addrs2[$];
  bit          done2 = 0;

  initial begin
    bit pend2;
    bus2_if.imem_req_ready = 1; bus2_if.imem_rsp_valid = 0; bus2_if.imem_rsp_data = 0;
    bus2_if.redirect_valid = 0; bus2_if.redirect_pc = 0; bus2_if.stall = 0;
    pend2 = 0;
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      bus2_if.imem_rsp_valid = pend2;
      #1;
      if (bus2_if.imem_req_valid) addrs2.push_back(bus2_if.imem_addr);
      pend2 = bus2_if.imem_req_valid;
      @(negedge clk);
    end
    done2 = 1;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] exp2 [3];
    bit found;
    mem_lat_max = 0; mem_rand_data = 0;
    clear_models();

    //          rdy rsp data          rdr rpc           stl req addr          iv instr         ipc
    tbl.push_back(mk(1, 0, 32'h0,      0, 32'h0,     0, 0, 32'h0,     0, 32'h13,    32'h0));
    tbl.push_back(mk(1, 0, 32'h0,      0, 32'h0,     0, 1, 32'h0,     0, 32'h13,    32'h0));
    tbl.push_back(mk(1, 1, 32'h0,      0, 32'h0,     0, 0, 32'h4,     0, 32'h13,    32'h0));
    tbl.push_back(mk(1, 0, 32'h0,      0, 32'h0,     0, 1, 32'h4,     1, 32'h0,     32'h0));
    tbl.push_back(mk(1, 1, 32'h1,      0, 32'h0,     0, 0, 32'h8,     0, 32'h13,    32'h0));
    tbl.push_back(mk(1, 0, 32'h0,      0, 32'h0,     0, 1, 32'h8,     1, 32'h1,     32'h4));
    tbl.push_back(mk(1, 1, 32'h2,      0, 32'h0,     0, 0, 32'hC,     0, 32'h13,    32'h0));
    tbl.push_back(mk(1, 0, 32'h0,      1, 32'h103,   0, 0, 32'hC,     1, 32'h2,     32'h8));
    tbl.push_back(mk(1, 0, 32'h0,      0, 32'h0,     0, 1, 32'h100,   0, 32'h13,    32'h0));
    tbl.push_back(mk(1, 1, 32'hDEAD,   1, 32'h200,   0, 0, 32'h104,   0, 32'h13,    32'h0));
    tbl.push_back(mk(1, 0, 32'h0,      0, 32'h0,     0, 1, 32'h200,   0, 32'h13,    32'h0));
    tbl.push_back(mk(1, 0, 32'h0,      1, 32'h303,   0, 0, 32'h204,   0, 32'h13,    32'h0));
    tbl.push_back(mk(1, 0, 32'h0,      1, 32'h400,   0, 0, 32'h300,   0, 32'h13,    32'h0));
    tbl.push_back(mk(1, 1, 32'hBAD,    0, 32'h0,     0, 0, 32'h400,   0, 32'h13,    32'h0));
    tbl.push_back(mk(0, 0, 32'h0,      0, 32'h0,     0, 1, 32'h400,   0, 32'h13,    32'h0));
    tbl.push_back(mk(1, 0, 32'h0,      0, 32'h0,     0, 1, 32'h400,   0, 32'h13,    32'h0));
    tbl.push_back(mk(1, 1, 32'h55,     0, 32'h0,     0, 0, 32'h404,   0, 32'h13,    32'h0));
    tbl.push_back(mk(1, 0, 32'h0,      0, 32'h0,     1, 1, 32'h404,   1, 32'h55,    32'h400));
    tbl.push_back(mk(1, 1, 32'h66,     0, 32'h0,     1, 0, 32'h408,   1, 32'h55,    32'h400));
    tbl.push_back(mk(1, 0, 32'h0,      0, 32'h0,     1, 0, 32'h408,   1, 32'h55,    32'h400));
    tbl.push_back(mk(1, 0, 32'h0,      0, 32'h0,     0, 0, 32'h408,   1, 32'h55,    32'h400));
    tbl.push_back(mk(0, 0, 32'h0,      0, 32'h0,     0, 1, 32'h408,   1, 32'h66,    32'h404));
    tbl.push_back(mk(0, 0, 32'h0,      0, 32'h0,     0, 1, 32'h408,   0, 32'h13,    32'h0));

    do_reset();
    foreach (tbl[i]) begin
      bus_if.imem_req_ready = tbl[i].rdy;
      bus_if.imem_rsp_valid = tbl[i].rsp;
      bus_if.imem_rsp_data  = tbl[i].rdata;
      bus_if.redirect_valid = tbl[i].redir;
      bus_if.redirect_pc    = tbl[i].rpc;
      bus_if.stall          = tbl[i].stl;
      #1;
      check($sformatf("tbl%0d_req_valid", i), 32'(bus_if.imem_req_valid), 32'(tbl[i].e_req));
      check($sformatf("tbl%0d_addr", i), bus_if.imem_addr, tbl[i].e_addr);
      check($sformatf("tbl%0d_instr_valid", i), 32'(bus_if.instr_valid), 32'(tbl[i].e_iv));
      check($sformatf("tbl%0d_instruction", i), bus_if.instruction, tbl[i].e_instr);
      check($sformatf("tbl%0d_instr_pc", i), bus_if.instr_pc, tbl[i].e_ipc);
      @(negedge clk);
    end

    // Redirect coinciding with a response and a would-be pop.
    do_reset();
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    step(1, 1, 32'h80, 0);
    check("coinc_instr_valid", 32'(bus_if.instr_valid), 32'h0);
    check("coinc_instruction", bus_if.instruction, 32'h0000_0013);
    check("coinc_instr_pc", bus_if.instr_pc, 32'h0);
    check("coinc_addr", bus_if.imem_addr, 32'h80);

    // Long stall fills the buffer, then drains without gaps.
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1);
    #1;
    check("stall_req_dropped", 32'(bus_if.imem_req_valid), 32'h0);
    check("stall_instr_pc", bus_if.instr_pc, 32'h80);
    check("stall_instruction", bus_if.instruction, 32'h20);
    @(negedge clk);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);

    // Reset asserted with a fetch in flight and instructions buffered.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out && mq.size() > 0) found = 1;
      else step(1, 0, 0, 1);
    end
    check("wait_state_reached", 32'(found), 32'h1);
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);

    // Randomised traffic against the model.
    mem_lat_max = 2; mem_rand_data = 1;
    do_reset();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(9, 0) < 7, $urandom_range(19, 0) == 0, $urandom,
           $urandom_range(9, 0) < 3);

    // PC wrap on the second instance.
    for (int i = 0; i < 100 && !done2; i++) @(negedge clk);
    check("wrap_done", 32'(done2), 32'h1);
    exp2[0] = 32'hFFFF_FFF8; exp2[1] = 32'hFFFF_FFFC; exp2[2] = 32'h0000_0000;
    for (int i = 0; i < 3; i++)
      check($sformatf("wrap_addr%0d", i), (i < addrs2.size()) ? addrs2[i] : 32'hDEAD_BEEF,
            exp2[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
